ahb_lite_subordinate_bridge: RTL and testbench
==============================================

# ahb_lite_subordinate_bridge

Synthesizable, parametrised AHB-Lite subordinate that converts pipelined AHB transfers into a single-outstanding valid/ready request and response backend interface. It adds what the simulation-only subordinate lacks: configurable data width, HSIZE-derived byte strobes, correct address/data-phase pipelining, backend-driven wait states, two-cycle ERROR responses, and a response timeout. It sits between the AHB interconnect and a memory-mapped peripheral or the Renode connection adapter.

## Interface
- ADDR_WIDTH, 32: HADDR and req_addr width.
- DATA_WIDTH, 32: HWDATA/HRDATA width; legal values are 32 or 64. NB = DATA_WIDTH/8 byte lanes.
- TIMEOUT, 255: cycles allowed between request handshake and rsp_valid; 0 disables the timeout.
- HCLK  in  1  bus clock; every flop is on the rising edge.
- HRESETn  in  1  synchronous, active-low reset. One clock; the polarity and synchronicity are fixed.
- HSEL, HREADY, HWRITE  in  1 each  select, bus ready and direction.
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- HSIZE  in  3  transfer size is 2^HSIZE bytes.
- HADDR  in  ADDR_WIDTH; HWDATA  in  DATA_WIDTH.
- HREADYOUT  out  1; HRESP  out  1 (0=OKAY, 1=ERROR); HRDATA  out  DATA_WIDTH.
- req_valid  out  1; req_ready  in  1; req_write  out  1; req_addr  out  ADDR_WIDTH; req_wdata  out  DATA_WIDTH; req_strb  out  NB.
- rsp_valid  in  1  single-cycle pulse with no backpressure; rsp_rdata  in  DATA_WIDTH; rsp_error  in  1.

## Operation
- Address-phase capture happens on a rising edge when HSEL & HREADY & HTRANS[1]. It registers HADDR, HWRITE and HSIZE. IDLE and BUSY transfers, or HSEL=0, give a zero-wait OKAY.
- Strobe: req_strb = ((1<<2^HSIZE)-1) << HADDR[log2(NB)-1:0].
- The bridge flags the transfer as illegal if 2^HSIZE > NB, or if HADDR is not aligned to 2^HSIZE. An illegal transfer goes to ERR1 and issues no backend request.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. A legal capture goes to REQ; an illegal capture goes to ERR1.
  - REQ: HREADYOUT=0, req_valid=1. req_wdata = HWDATA as sampled this cycle; the bridge holds it internally and does not require the manager to hold it. The request fields are stable until req_ready. On req_valid & req_ready, go to WAIT.
  - WAIT: HREADYOUT=0. On rsp_valid, register HRDATA ← rsp_rdata (reads only; writes leave HRDATA unchanged) and HRESP ← rsp_error. If rsp_error=0, go to DONE. If rsp_error=1, go to ERR2; the HRESP=1, HREADYOUT=0 cycle occurs in WAIT's final registered output.
  - DONE: HREADYOUT=1, HRESP=0. This is the final data-phase cycle. A capture in DONE goes directly to REQ or ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Capture is allowed here, as in DONE.
  - DRAIN: entered on timeout. The bridge first completes the two-cycle ERROR, then discards the late rsp_valid. A transfer captured while draining is held in its data phase with HREADYOUT=0 and enters REQ the cycle after the discarded rsp_valid.
- Timeout: a counter clears on the request handshake and increments in WAIT. When it reaches TIMEOUT without rsp_valid, the bridge enters the ERR1 sequence and sets the drain flag.
- A backend error and a timeout share the two-cycle ERROR encoding.

## Timing
- Reset, applied when HRESETn=0 at an edge, forces HREADYOUT=1, HRESP=0, HRDATA=0, req_valid=0, req_strb=0, state=IDLE, counter=0 and drain flag=0. Reset in the middle of a transfer abandons it; a later rsp_valid is ignored.
- Minimum transfer, with req_ready=1 and rsp_valid one cycle after the handshake:
  - address phase at edge N;
  - REQ during cycle N+1;
  - WAIT during N+2, with rsp_valid;
  - DONE with HREADYOUT=1 during N+3;
  - this gives 2 wait states.
- The earliest accepted rsp_valid is the cycle after the handshake. rsp_valid outside WAIT or DRAIN is ignored.
- Back-to-back transfers: an address phase presented during DONE or ERR2 is captured at that cycle's edge with no idle cycle.
- HRESP=1 is always asserted for exactly one cycle with HREADYOUT=0, followed by one cycle with HREADYOUT=1.

## Test plan
- Word read: DATA_WIDTH=32, read at 0x100 with HSIZE=2, req_ready=1, rsp_rdata=0xDEADBEEF one cycle after the handshake. Required: req_strb=4'b1111; HRDATA=0xDEADBEEF with HREADYOUT=1 three cycles after the address phase; HRESP=0.
- Byte write: write at 0x103 with HSIZE=0 and HWDATA=0xAB000000. Required: req_strb=4'b1000, req_wdata=0xAB000000, req_write=1.
- Misaligned and oversize: HSIZE=2 at 0x102, and HSIZE=3 with DATA_WIDTH=32. Required: no req_valid, then HRESP=1/HREADYOUT=0 followed by HRESP=1/HREADYOUT=1.
- Backpressure and back-to-back: req_ready held low for 5 cycles, with a second NONSEQ presented during DONE. Required: req fields stable while req_ready is low; the second REQ starts the cycle after DONE.
- Timeout: TIMEOUT=8, rsp_valid withheld. Required: ERROR at counter 8. A late rsp_valid with rsp_rdata=0x1234 is discarded, and the next read returns its own data.
- Reset mid-transfer: HRESETn=0 for 1 cycle during WAIT. Required: all outputs at their reset values on the next edge; a subsequent read completes normally.

Source files
------------

// File: rtl/ahb_lite_subordinate_bridge.sv
// rtl/ahb_lite_subordinate_bridge.sv - AHB-Lite subordinate to single-outstanding valid/ready backend bridge
module ahb_lite_subordinate_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    HSEL,
   input  logic                    HREADY,
   input  logic                    HWRITE,
   input  logic [1:0]              HTRANS,
   input  logic [2:0]              HSIZE,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   output logic                    HREADYOUT,
   output logic                    HRESP,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic                    req_write,
   output logic [ADDR_WIDTH-1:0]   req_addr,
   output logic [DATA_WIDTH-1:0]   req_wdata,
   output logic [DATA_WIDTH/8-1:0] req_strb,
   input  logic                    rsp_valid,
   input  logic [DATA_WIDTH-1:0]   rsp_rdata,
   input  logic                    rsp_error
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int LW = $clog2(NB);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR1, S_ERR2, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [NB-1:0]         strb_q, strb_c;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic                  wdata_held_q;
   logic                  drain_q, drain_d;
   logic                  pending_q, pending_d;
   logic [CW-1:0]         cnt_q;
   logic [7:0]            xfer_bytes;
   logic [LW-1:0]         lane_off;
   logic                  illegal, capture, accepting;

   always_comb begin
      xfer_bytes = 8'd1 << HSIZE;
      lane_off   = HADDR[LW-1:0];
      illegal    = (xfer_bytes > 8'(NB)) || ((lane_off & (xfer_bytes[LW-1:0] - LW'(1))) != '0);
      for (int i = 0; i < NB; i++)
         strb_c[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + int'(xfer_bytes));
   end

   assign capture   = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);
   // States that end a data phase with HREADYOUT=1 may accept the next address phase
   assign accepting = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2) ||
                      (state_q == S_DRAIN && !pending_q);

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      pending_d = pending_q;
      if (accepting) begin
         if (state_q == S_DRAIN && rsp_valid) drain_d = 1'b0;
         if (capture && illegal) begin
            state_d = S_ERR1;
         end else if (drain_d) begin
            state_d   = S_DRAIN;
            pending_d = capture;
         end else begin
            state_d = capture ? S_REQ : S_IDLE;
         end
      end else begin
         case (state_q)
            S_REQ:  if (req_ready) state_d = S_WAIT;
            S_WAIT: begin
               if (rsp_valid) begin
                  state_d = rsp_error ? S_ERR2 : S_DONE;
               end else if (TIMEOUT != 0 && cnt_q == TO_LIMIT) begin
                  state_d = S_ERR1;
                  drain_d = 1'b1;
               end
            end
            S_ERR1: state_d = S_ERR2;
            // Held transfer waits for the stale response before issuing its own request
            S_DRAIN: if (rsp_valid) begin
               drain_d   = 1'b0;
               pending_d = 1'b0;
               state_d   = S_REQ;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state_q)
         S_REQ:   HREADYOUT = 1'b0;
         S_WAIT:  begin
            HREADYOUT = 1'b0;
            HRESP     = rsp_valid && rsp_error;
         end
         S_ERR1:  begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         S_ERR2:  HRESP = 1'b1;
         S_DRAIN: HREADYOUT = !pending_q;
         default: ;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q      <= S_IDLE;
         drain_q      <= 1'b0;
         pending_q    <= 1'b0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         strb_q       <= '0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         wdata_held_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         pending_q <= pending_d;
         if (capture && accepting && !illegal) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            strb_q  <= strb_c;
         end
         // First REQ cycle forwards HWDATA live and latches it for any backpressured cycles
         if (state_q == S_REQ) begin
            wdata_held_q <= !req_ready;
            if (!wdata_held_q) wdata_q <= HWDATA;
         end else begin
            wdata_held_q <= 1'b0;
         end
         if (state_q == S_REQ && req_ready) cnt_q <= '0;
         else if (state_q == S_WAIT)        cnt_q <= cnt_q + 1'b1;
         if (state_q == S_WAIT && rsp_valid && !write_q) rdata_q <= rsp_rdata;
      end
   end

   assign HRDATA    = rdata_q;
   assign req_valid = (state_q == S_REQ);
   assign req_write = write_q;
   assign req_addr  = addr_q;
   assign req_strb  = strb_q;
   assign req_wdata = wdata_held_q ? wdata_q : HWDATA;
endmodule

// File: tb/tb_ahb_lite_subordinate_bridge.sv
// tb/tb_ahb_lite_subordinate_bridge.sv - self-checking bench for ahb_lite_subordinate_bridge
module tb_ahb_lite_subordinate_bridge;
   localparam int TO = 8;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic        HWRITE = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [2:0]  HSIZE = 3'd0;
   logic [31:0] HADDR = '0;
   logic [31:0] HWDATA = '0;
   logic        HREADY;
   logic        HREADYOUT, HRESP;
   logic [31:0] HRDATA;
   logic        req_valid, req_write;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid = 1'b0;
   logic        rsp_error = 1'b0;
   logic [31:0] rsp_rdata = '0;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_hrdata;

   assign HREADY = HREADYOUT;
   always #5 HCLK = ~HCLK;

   ahb_lite_subordinate_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input string tag, input bit rdy, input bit resp, input bit rv);
      chk({tag, ".hreadyout"}, 64'(HREADYOUT), 64'(rdy));
      chk({tag, ".hresp"}, 64'(HRESP), 64'(resp));
      chk({tag, ".req_valid"}, 64'(req_valid), 64'(rv));
   endtask

   task automatic addr_phase(input bit wr, input logic [31:0] a, input logic [2:0] sz);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
   endtask

   // One clock: advance, drive the next cycle's inputs on the falling edge, settle
   task automatic step(input bit rr, input bit rv, input logic [31:0] rd, input bit re, input logic [31:0] hw);
      @(posedge HCLK);
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      req_ready = rr; rsp_valid = rv; rsp_rdata = rd; rsp_error = re; HWDATA = hw;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
         bus("idle", 1'b1, 1'b0, 1'b0);
      end
   endtask

   // Full transfer from address phase to final data-phase cycle; rdly = cycles req_ready
   // is withheld, sdly = cycles from handshake to rsp_valid
   task automatic do_xfer(input string tag, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [31:0] rd, input bit err,
                          input int rdly, input int sdly);
      int       bytes, hs, rk, last;
      bit       legal;
      logic [3:0] strb;
      bytes = 1 << sz;
      legal = (bytes <= 4) && ((a % 32'(bytes)) == 0);
      strb  = legal ? 4'(((1 << bytes) - 1) << (a % 4)) : 4'b0;
      hs    = legal ? rdly : -1;
      rk    = legal ? rdly + sdly : -1;
      last  = legal ? rdly + sdly + 1 : 1;
      addr_phase(wr, a, sz);
      for (int k = 0; k <= last; k++) begin
         step(k == hs, (k == rk) || (k <= hs && $urandom_range(3) == 0),
              (k == rk) ? rd : $urandom, err, (k == 0) ? wd : $urandom);
         if (k < last) bus(tag, 1'b0, legal ? (k == rk && err) : 1'b1, legal && k <= hs);
         else          bus(tag, 1'b1, legal ? err : 1'b1, 1'b0);
         if (legal && k <= hs) begin
            chk({tag, ".req_addr"}, 64'(req_addr), 64'(a));
            chk({tag, ".req_write"}, 64'(req_write), 64'(wr));
            chk({tag, ".req_strb"}, 64'(req_strb), 64'(strb));
            if (wr) chk({tag, ".req_wdata"}, 64'(req_wdata), 64'(wd));
         end
         if (k == last) begin
            if (legal && !wr) exp_hrdata = rd;
            chk({tag, ".hrdata"}, 64'(HRDATA), 64'(exp_hrdata));
         end
      end
   endtask

   initial begin
      bit          wr, err;
      logic [2:0]  sz;
      logic [31:0] a;
      exp_hrdata = '0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      bus("reset", 1'b1, 1'b0, 1'b0);
      chk("reset.hrdata", 64'(HRDATA), 64'h0);
      chk("reset.req_strb", 64'(req_strb), 64'h0);

      do_xfer("word_rd", 1'b0, 32'h100, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1);
      idle(1);
      do_xfer("byte_wr", 1'b1, 32'h103, 3'd0, 32'hAB000000, 32'h0, 1'b0, 0, 1);
      do_xfer("misalign", 1'b0, 32'h102, 3'd2, 32'h0, 32'h0, 1'b0, 0, 1);
      do_xfer("oversize", 1'b1, 32'h100, 3'd3, 32'h0, 32'h0, 1'b0, 0, 1);
      do_xfer("bp_wr", 1'b1, 32'h200, 3'd2, 32'h5555AAAA, 32'h0, 1'b0, 5, 2);
      do_xfer("b2b_rd", 1'b0, 32'h204, 3'd2, 32'h0, 32'h13572468, 1'b0, 0, 1);
      do_xfer("be_err", 1'b0, 32'h302, 3'd1, 32'h0, 32'hCAFE0000, 1'b1, 1, 1);
      idle(2);

      // Response withheld: counter covers 0..TO in WAIT, then the ERROR pair
      addr_phase(1'b0, 32'h40, 3'd2);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("to.req", 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= TO; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         bus("to.wait", 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("to.err1", 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("to.err2", 1'b1, 1'b1, 1'b0);
      addr_phase(1'b0, 32'h44, 3'd2);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         bus("to.drain", 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, 32'h1234, 1'b0, 32'h0);
      bus("to.late", 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("to.req2", 1'b0, 1'b0, 1'b1);
      chk("to.req2_addr", 64'(req_addr), 64'h44);
      chk("to.hrdata_kept", 64'(HRDATA), 64'(exp_hrdata));
      step(1'b0, 1'b1, 32'h89ABCDEF, 1'b0, 32'h0);
      bus("to.wait2", 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("to.done2", 1'b1, 1'b0, 1'b0);
      exp_hrdata = 32'h89ABCDEF;
      chk("to.hrdata", 64'(HRDATA), 64'(exp_hrdata));

      // Reset during WAIT abandons the transfer
      addr_phase(1'b0, 32'h80, 3'd2);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("rst.req", 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      bus("rst.wait", 1'b0, 1'b0, 1'b0);
      HRESETn = 1'b0;
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      HRESETn = 1'b1;
      exp_hrdata = '0;
      bus("rst.after", 1'b1, 1'b0, 1'b0);
      chk("rst.hrdata", 64'(HRDATA), 64'h0);
      chk("rst.req_strb", 64'(req_strb), 64'h0);
      step(1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 32'h0);
      bus("rst.stray", 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rst.stray_hrdata", 64'(HRDATA), 64'h0);
      do_xfer("rst.rd", 1'b0, 32'h84, 3'd2, 32'h0, 32'h600DF00D, 1'b0, 1, 2);

      for (int n = 0; n < 40; n++) begin
         wr  = 1'($urandom_range(1));
         sz  = 3'($urandom_range(3));
         a   = $urandom;
         if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         err = ($urandom_range(7) == 0);
         do_xfer("rand", wr, a, sz, $urandom, $urandom, err, $urandom_range(3), 1 + $urandom_range(2));
         if ($urandom_range(1) == 1) idle(1 + $urandom_range(1));
      end
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
